// File: rtl/prog_ctr_inst_rom.sv
// Instruction-fetch front end: 10-bit program counter driving a 1024x9 instruction ROM.
// Start edges load the resident programs in rotation; while running the PC steps or branches.
module prog_ctr_inst_rom #(
  parameter logic [9:0] PROG1_ADDR = 10'd0,
  parameter logic [9:0] PROG2_ADDR = 10'd256,
  parameter logic [9:0] PROG3_ADDR = 10'd512
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       BranchRel,
  input  logic       BranchAbs,
  input  logic       ALU_flag,
  input  logic [9:0] Target,
  output logic [9:0] ProgCtr,
  output logic [8:0] InstOut
);

  logic       running;
  logic       startQ;
  logic [1:0] progIdx;
  logic       startEdge;
  logic [9:0] loadAddr;

  assign startEdge = Start & ~startQ;

  always_comb begin
    loadAddr = PROG1_ADDR;
    case (progIdx)
      2'd0:    loadAddr = PROG1_ADDR;
      2'd1:    loadAddr = PROG2_ADDR;
      default: loadAddr = PROG3_ADDR;
    endcase
  end

  // A start edge outranks any branch request on the same edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ProgCtr <= '0;
      running <= 1'b0;
      progIdx <= 2'd0;
      startQ  <= 1'b0;
    end else begin
      startQ <= Start;
      if (startEdge) begin
        ProgCtr <= loadAddr;
        running <= 1'b1;
        progIdx <= (progIdx == 2'd2) ? 2'd0 : progIdx + 2'd1;
      end else if (running) begin
        if (BranchAbs)
          ProgCtr <= Target;
        else if (BranchRel && ALU_flag)
          ProgCtr <= ProgCtr + Target;
        else
          ProgCtr <= ProgCtr + 10'd1;
      end
    end
  end

  // Resident image held as a constant table; every word not listed reads as zero.
  always_comb begin
    InstOut = 9'b0;
    case (ProgCtr)
      PROG1_ADDR: InstOut = 9'b011011100;
      PROG2_ADDR: InstOut = 9'b000001011;
      PROG3_ADDR: InstOut = 9'b110001000;
      default:    InstOut = 9'b0;
    endcase
  end

endmodule

// File: tb/tb_prog_ctr_inst_rom.sv
// Directed bench for prog_ctr_inst_rom: program loads, branches, wrap, start-edge rules, async reset.
module tb_prog_ctr_inst_rom;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       BranchRel = 1'b0;
  logic       BranchAbs = 1'b0;
  logic       ALU_flag = 1'b0;
  logic [9:0] Target = '0;
  logic [9:0] ProgCtr;
  logic [8:0] InstOut;

  int total = 0;
  int bad = 0;

  localparam logic [8:0] W1 = 9'b011011100;
  localparam logic [8:0] W2 = 9'b000001011;
  localparam logic [8:0] W3 = 9'b110001000;

  prog_ctr_inst_rom dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchRel(BranchRel),
    .BranchAbs(BranchAbs), .ALU_flag(ALU_flag), .Target(Target),
    .ProgCtr(ProgCtr), .InstOut(InstOut)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    check("reset_pc", ProgCtr, 10'd0);
    check("reset_inst", {1'b0, InstOut}, {1'b0, W1});

    Reset = 1'b1;
    step();
    check("idle_pc", ProgCtr, 10'd0);
    BranchAbs = 1'b1; Target = 10'd5;
    step();
    check("idle_branch_ignored", ProgCtr, 10'd0);
    BranchAbs = 1'b0; Target = 10'd0;

    Start = 1'b1;
    step();
    check("load1_pc", ProgCtr, 10'd0);
    check("load1_inst", {1'b0, InstOut}, {1'b0, W1});
    Start = 1'b0;
    step();
    check("run_inc", ProgCtr, 10'd1);

    Start = 1'b1;
    step();
    check("load2_pc", ProgCtr, 10'd256);
    check("load2_inst", {1'b0, InstOut}, {1'b0, W2});
    Start = 1'b0;
    step();
    check("load2_inc", ProgCtr, 10'd257);
    check("unused_word", {1'b0, InstOut}, 10'd0);
    Start = 1'b1;
    step();
    check("load3_pc", ProgCtr, 10'd512);
    check("load3_inst", {1'b0, InstOut}, {1'b0, W3});
    Start = 1'b0;
    step();
    check("load3_inc", ProgCtr, 10'd513);
    Start = 1'b1;
    step();
    check("load4_wrap_pc", ProgCtr, 10'd0);
    Start = 1'b0;

    BranchAbs = 1'b1; Target = 10'd10;
    step();
    check("abs_to_10", ProgCtr, 10'd10);
    Target = 10'd700;
    step();
    check("abs_to_700", ProgCtr, 10'd700);
    BranchAbs = 1'b0; BranchRel = 1'b1; ALU_flag = 1'b1; Target = 10'h3FE;
    step();
    check("rel_minus2", ProgCtr, 10'd698);
    ALU_flag = 1'b0;
    step();
    check("rel_not_taken", ProgCtr, 10'd699);

    BranchRel = 1'b1; BranchAbs = 1'b1; ALU_flag = 1'b1; Target = 10'd1023;
    step();
    check("abs_beats_rel", ProgCtr, 10'd1023);
    BranchAbs = 1'b0; BranchRel = 1'b0; ALU_flag = 1'b0;
    step();
    check("inc_wrap", ProgCtr, 10'd0);
    BranchAbs = 1'b1; Target = 10'd1020;
    step();
    BranchAbs = 1'b0; BranchRel = 1'b1; ALU_flag = 1'b1; Target = 10'd10;
    step();
    check("rel_wrap", ProgCtr, 10'd6);
    BranchRel = 1'b0; ALU_flag = 1'b0;

    Start = 1'b1; BranchAbs = 1'b1; Target = 10'd300;
    step();
    check("start_beats_branch", ProgCtr, 10'd256);
    BranchAbs = 1'b0; Target = 10'd0; Start = 1'b0;
    step();
    check("after_start_branch", ProgCtr, 10'd257);

    Start = 1'b1;
    step();
    check("held_load", ProgCtr, 10'd512);
    step();
    check("held_no_reload1", ProgCtr, 10'd513);
    step();
    check("held_no_reload2", ProgCtr, 10'd514);
    Start = 1'b0;
    step();
    check("held_release", ProgCtr, 10'd515);

    #2;
    Reset = 1'b0;
    #1;
    check("async_reset_pc", ProgCtr, 10'd0);
    #2;
    Reset = 1'b1;
    step();
    check("post_reset_idle", ProgCtr, 10'd0);
    Start = 1'b1;
    step();
    check("post_reset_load1", ProgCtr, 10'd0);
    check("post_reset_inst", {1'b0, InstOut}, {1'b0, W1});
    Start = 1'b0;
    step();
    check("post_reset_run", ProgCtr, 10'd1);
    Start = 1'b1;
    step();
    check("post_reset_load2", ProgCtr, 10'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
